// File: rtl/pipeline_hazard_ctrl_pkg.sv
//------------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared encodings for the 3-stage pipeline hazard controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [1:0]  FWD_REGFILE = 2'b00;
  localparam logic [1:0]  FWD_X       = 2'b01;
  localparam logic [1:0]  FWD_M       = 2'b10;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       load;
    logic [4:0] rd;
  } shadow_t;

  // Youngest producer wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input shadow_t   x_ent,
                                         input shadow_t   m_ent);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (rs != 5'd0) begin
      if (x_ent.valid && x_ent.we && (x_ent.rd == rs))
        sel = FWD_X;
      else if (m_ent.valid && m_ent.we && (m_ent.rd == rs))
        sel = FWD_M;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_shadow_regs.sv
//------------------------------------------------------------------------------
// pipeline_hazard_ctrl_shadow_regs
// Two-entry (X, M) in-flight destination shadow, load-use detect, forwarding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl_shadow_regs
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       bubble,
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_uses_rs1,
  input  logic       d_uses_rs2,
  input  logic [4:0] d_rd,
  input  logic       d_reg_write_en,
  input  logic       d_mem_read_en,
  output logic       load_use,
  output logic [1:0] x_fwd_rs1,
  output logic [1:0] x_fwd_rs2
);

  shadow_t    r_x;
  shadow_t    r_m;
  logic [1:0] r_fwd_rs1;
  logic [1:0] r_fwd_rs2;
  shadow_t    w_new;
  logic       w_issue;
  logic       w_x_is_load;

  always_comb begin
    w_issue     = d_valid & ~bubble;
    w_new.valid = w_issue;
    w_new.we    = w_issue & d_reg_write_en & (d_rd != 5'd0);
    w_new.load  = w_issue & d_mem_read_en;
    w_new.rd    = d_rd;
  end

  assign w_x_is_load = r_x.valid & r_x.load & (r_x.rd != 5'd0);
  assign load_use    = w_x_is_load & d_valid &
                       ((d_uses_rs1 & (d_rs1 == r_x.rd)) |
                        (d_uses_rs2 & (d_rs2 == r_x.rd)));

  // Selects are computed against the pre-advance shadow so they line up with X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_m       <= '0;
      r_fwd_rs1 <= FWD_REGFILE;
      r_fwd_rs2 <= FWD_REGFILE;
    end else if (advance) begin
      r_m       <= r_x;
      r_x       <= w_new;
      r_fwd_rs1 <= w_issue ? fwd_sel(d_rs1, r_x, r_m) : FWD_REGFILE;
      r_fwd_rs2 <= w_issue ? fwd_sel(d_rs2, r_x, r_m) : FWD_REGFILE;
    end
  end

  assign x_fwd_rs1 = r_fwd_rs1;
  assign x_fwd_rs2 = r_fwd_rs2;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Load-use / control hazard sequencer with stall, bubble and forwarding control.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_uses_rs1,
  input  logic       d_uses_rs2,
  input  logic [4:0] d_rd,
  input  logic       d_reg_write_en,
  input  logic       d_mem_read_en,
  input  logic       x_redirect,
  input  logic       mem_busy,
  output logic       pc_stall,
  output logic       fd_stall,
  output logic       nop_inject,
  output logic [1:0] x_fwd_rs1,
  output logic [1:0] x_fwd_rs2,
  output logic [1:0] busy_state
);

  localparam logic [1:0] c_load_cnt  = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0] c_flush_cnt = 2'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     r_saved;
  logic [1:0] r_cnt;
  state_t     w_cur;
  state_t     w_next;
  state_t     w_saved_next;
  logic [1:0] w_cnt_next;
  logic       w_advance;
  logic       w_load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_saved <= w_saved_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // r_cnt holds the bubbles still owed, including the one issued this cycle.
  always_comb begin
    w_cur        = (r_state == ST_MEM_WAIT) ? r_saved : r_state;
    w_next       = w_cur;
    w_saved_next = r_saved;
    w_cnt_next   = r_cnt;
    w_advance    = 1'b1;
    pc_stall     = 1'b0;
    fd_stall     = 1'b0;
    nop_inject   = 1'b0;

    if (rst) begin
      nop_inject = 1'b1;
      w_advance  = 1'b0;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      fd_stall     = 1'b1;
      w_advance    = 1'b0;
      w_next       = ST_MEM_WAIT;
      w_saved_next = w_cur;
    end else if (x_redirect) begin
      nop_inject = 1'b1;
      w_cnt_next = c_flush_cnt;
      w_next     = (c_flush_cnt != 2'd0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (w_cur)
        ST_LOAD_STALL, ST_FLUSH: begin
          nop_inject = 1'b1;
          pc_stall   = (w_cur == ST_LOAD_STALL);
          fd_stall   = (w_cur == ST_LOAD_STALL);
          if (r_cnt <= 2'd1) begin
            w_next     = ST_RUN;
            w_cnt_next = 2'd0;
          end else begin
            w_cnt_next = r_cnt - 2'd1;
          end
        end
        default: begin
          w_next = ST_RUN;
          if (w_load_use) begin
            pc_stall   = 1'b1;
            fd_stall   = 1'b1;
            nop_inject = 1'b1;
            w_cnt_next = c_load_cnt;
            w_next     = (c_load_cnt != 2'd0) ? ST_LOAD_STALL : ST_RUN;
          end
        end
      endcase
    end
  end

  pipeline_hazard_ctrl_shadow_regs u_shadow (
    .clk            (clk),
    .rst            (rst),
    .advance        (w_advance),
    .bubble         (nop_inject),
    .d_valid        (d_valid),
    .d_rs1          (d_rs1),
    .d_rs2          (d_rs2),
    .d_uses_rs1     (d_uses_rs1),
    .d_uses_rs2     (d_uses_rs2),
    .d_rd           (d_rd),
    .d_reg_write_en (d_reg_write_en),
    .d_mem_read_en  (d_mem_read_en),
    .load_use       (w_load_use),
    .x_fwd_rs1      (x_fwd_rs1),
    .x_fwd_rs2      (x_fwd_rs2)
  );

  assign busy_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed and random stimulus against a bubble-count reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int LB = 1;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_valid;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic       d_uses_rs1;
  logic       d_uses_rs2;
  logic [4:0] d_rd;
  logic       d_reg_write_en;
  logic       d_mem_read_en;
  logic       x_redirect;
  logic       mem_busy;
  logic       pc_stall;
  logic       fd_stall;
  logic       nop_inject;
  logic [1:0] x_fwd_rs1;
  logic [1:0] x_fwd_rs2;
  logic [1:0] busy_state;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(LB), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst            (rst),
    .d_valid        (d_valid),
    .d_rs1          (d_rs1),
    .d_rs2          (d_rs2),
    .d_uses_rs1     (d_uses_rs1),
    .d_uses_rs2     (d_uses_rs2),
    .d_rd           (d_rd),
    .d_reg_write_en (d_reg_write_en),
    .d_mem_read_en  (d_mem_read_en),
    .x_redirect     (x_redirect),
    .mem_busy       (mem_busy),
    .pc_stall       (pc_stall),
    .fd_stall       (fd_stall),
    .nop_inject     (nop_inject),
    .x_fwd_rs1      (x_fwd_rs1),
    .x_fwd_rs2      (x_fwd_rs2),
    .busy_state     (busy_state)
  );

  // Reference model: in-flight instructions plus a count of owed bubbles.
  typedef struct { bit v; bit we; bit ld; int rd; } ent_t;
  ent_t mx;
  ent_t mm;
  int   left;
  int   kind;
  bit   frozen;
  int   exp_f1;
  int   exp_f2;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fsel(input int rs);
    if (rs != 0 && mx.v && mx.we && mx.rd == rs) return 1;
    if (rs != 0 && mm.v && mm.we && mm.rd == rs) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    mx = '{v: 0, we: 0, ld: 0, rd: 0};
    mm = '{v: 0, we: 0, ld: 0, rd: 0};
    left = 0; kind = 0; frozen = 0; exp_f1 = 0; exp_f2 = 0;
  endtask

  task automatic step(input bit dv, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit we, input bit ld, input bit redir, input bit busy);
    bit e_stall;
    bit e_nop;
    bit haz;
    bit issue;
    int e_state;
    @(negedge clk);
    d_valid = dv; d_rs1 = 5'(rs1); d_rs2 = 5'(rs2); d_uses_rs1 = u1; d_uses_rs2 = u2;
    d_rd = 5'(rd); d_reg_write_en = we; d_mem_read_en = ld; x_redirect = redir; mem_busy = busy;
    #1;
    e_state = frozen ? 3 : ((left > 0) ? kind : 0);
    haz = mx.v && mx.ld && mx.rd != 0 && dv && ((u1 && rs1 == mx.rd) || (u2 && rs2 == mx.rd));
    e_stall = 0; e_nop = 0;
    if (busy) e_stall = 1;
    else if (redir) e_nop = 1;
    else if (left > 0) begin e_nop = 1; e_stall = (kind == 1); end
    else if (haz) begin e_nop = 1; e_stall = 1; end
    check_eq("busy_state", 8'(busy_state), 8'(e_state));
    check_eq("x_fwd_rs1", 8'(x_fwd_rs1), 8'(exp_f1));
    check_eq("x_fwd_rs2", 8'(x_fwd_rs2), 8'(exp_f2));
    check_eq("pc_stall", 8'(pc_stall), 8'(e_stall));
    check_eq("fd_stall", 8'(fd_stall), 8'(e_stall));
    check_eq("nop_inject", 8'(nop_inject), 8'(e_nop));
    if (busy) begin
      frozen = 1;
    end else begin
      frozen = 0;
      if (redir) begin left = FC - 1; kind = 2; end
      else if (left > 0) left--;
      else if (haz) begin left = LB - 1; kind = 1; end
      issue  = dv && !e_nop;
      exp_f1 = issue ? fsel(rs1) : 0;
      exp_f2 = issue ? fsel(rs2) : 0;
      mm = mx;
      mx = '{v: issue, we: issue && we && rd != 0, ld: issue && ld, rd: rd};
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_in_reset();
    check_eq("rst_nop_inject", 8'(nop_inject), 8'd1);
    check_eq("rst_pc_stall", 8'(pc_stall), 8'd0);
    check_eq("rst_fd_stall", 8'(fd_stall), 8'd0);
    check_eq("rst_busy_state", 8'(busy_state), 8'd0);
    check_eq("rst_x_fwd_rs1", 8'(x_fwd_rs1), 8'd0);
    check_eq("rst_x_fwd_rs2", 8'(x_fwd_rs2), 8'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_in_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_uses_rs1 = 0; d_uses_rs2 = 0;
    d_rd = 0; d_reg_write_en = 0; d_mem_read_en = 0; x_redirect = 0; mem_busy = 0;
    model_reset();
    #2 check_in_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // LW x5,0(x1); ADD x6,x5,x2 held through one stall, then forwarded from M.
    step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    step(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    step(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    idle();
    check_eq("lw_add_fwd_m", 8'(x_fwd_rs1), 8'd2);

    // ADD x3,x1,x2; SUB x4,x3,x3: back-to-back X forwarding.
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    idle();
    check_eq("add_sub_fwd_x", 8'({x_fwd_rs1, x_fwd_rs2}), 8'b0101);

    // LW x0 then ADD x6,x0,x0: x0 never hazards or forwards.
    step(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
    idle();

    // Redirect from RUN, then redirect with a memory freeze in the flush.
    step(1, 1, 2, 1, 1, 7, 1, 0, 1, 0);
    repeat (3) step(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(1, 1, 2, 1, 1, 8, 1, 0, 0, 1);
    repeat (3) idle();

    // Load-use coinciding with a redirect, then reset mid-flush.
    step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    step(1, 5, 2, 1, 1, 6, 1, 0, 1, 0);
    step(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    reset_mid();
    step(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
    idle();

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 85,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 7, $urandom_range(0, 99) < 12);
      if (i % 500 == 250) reset_mid();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
